serial_digit_adder: RTL and testbench

//   Parametrised digit-serial adder, successor to the 4-bit combinational

---
 rtl/serial_digit_adder_if.sv | 28 ++
 rtl/serial_digit_adder.sv | 140 ++++++++++++++
 tb/tb_serial_digit_adder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_digit_adder_if.sv
// Request/result bundle for the digit-serial adder. The requester drives the
// operands and start; the adder drives back the sum and status flags.
interface serial_digit_adder_if #(
    parameter int NDIG = 4
) ();
    localparam int W = 4 * NDIG;

    logic         start;
    logic         bcd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, bcd, a, b, cin,
        input  s, cout, busy, done, err
    );

    modport slave (
        input  start, bcd, a, b, cin,
        output s, cout, busy, done, err
    );
endinterface

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: one 4-bit digit per clock, LSD first, in either binary
// or packed-BCD mode. The result is held until the next request is accepted.
module serial_digit_adder #(
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_digit_adder_if.slave  bus
);
    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [W-1:0]  s_q,     s_d;
    logic          bcd_q,   bcd_d;
    logic          carry_q, carry_d;
    logic          cout_q,  cout_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;

    logic [3:0]    ad, bd, sd;
    logic [4:0]    t;
    logic          dig_carry;
    logic          dig_err;
    logic [W-1:0]  s_ins;

    // Select the current digit with a one-hot compare so no variable part-select is needed.
    always_comb begin
        ad    = 4'd0;
        bd    = 4'd0;
        s_ins = s_q;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                ad = a_q[4*i +: 4];
                bd = b_q[4*i +: 4];
                s_ins[4*i +: 4] = sd;
            end
        end
    end

    always_comb begin
        t       = {1'b0, ad} + {1'b0, bd} + {4'b0000, carry_q};
        dig_err = bcd_q & ((ad > 4'd9) | (bd > 4'd9));
        if (!bcd_q) begin
            sd        = t[3:0];
            dig_carry = t[4];
        end else if (t > 5'd9) begin
            sd        = t[3:0] + 4'd6;
            dig_carry = 1'b1;
        end else begin
            sd        = t[3:0];
            dig_carry = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    bcd_d   = bus.bcd;
                    carry_d = bus.cin;
                    s_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d     = s_ins;
                carry_d = dig_carry;
                err_d   = err_q | dig_err;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = dig_carry;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            bcd_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for the digit-serial adder: a 4-digit instance for the
// functional cases and a 1-digit instance for an exhaustive digit sweep.
module tb_serial_digit_adder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_digit_adder_if #(.NDIG(4)) b4 ();
    serial_digit_adder_if #(.NDIG(1)) b1 ();

    serial_digit_adder #(.NDIG(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    serial_digit_adder #(.NDIG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch4(input logic m, input logic [15:0] av, input logic [15:0] bv,
                           input logic c);
        @(negedge clk);
        b4.start = 1'b1; b4.bcd = m; b4.a = av; b4.b = bv; b4.cin = c;
        @(posedge clk); #1;
        b4.start = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!b4.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op1(input logic m, input logic [3:0] av, input logic [3:0] bv,
                       input logic c, output int lat);
        @(negedge clk);
        b1.start = 1'b1; b1.bcd = m; b1.a = av; b1.b = bv; b1.cin = c;
        @(posedge clk); #1;
        b1.start = 1'b0;
        lat = 0;
        while (!b1.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op4_check(input string tag, input logic m, input logic [15:0] av,
                             input logic [15:0] bv, input logic c,
                             input logic [15:0] es, input logic ec, input logic ee);
        int lat;
        launch4(m, av, bv, c);
        wait4(lat);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_s"}, b4.s, es);
        check({tag, "_cout"}, b4.cout, ec);
        check({tag, "_err"}, b4.err, ee);
        $display("op %s: a=%h b=%h cin=%0d bcd=%0d -> s=%h cout=%0d err=%0d lat=%0d",
                 tag, av, bv, c, m, b4.s, b4.cout, b4.err, lat);
    endtask

    initial begin
        int lat, lat2, npulse, nd;
        logic [15:0] s_cap;
        logic        c_cap;
        int v, e;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        b4.start = 1'b0; b4.bcd = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0;
        b1.start = 1'b0; b1.bcd = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", b4.s, 16'h0000);
        check("rst_cout", b4.cout, 1'b0);
        check("rst_busy", b4.busy, 1'b0);
        check("rst_done", b4.done, 1'b0);
        check("rst_err", b4.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op4_check("bin_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4_check("bcd_9999_1", 1'b1, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4_check("bcd_459_367", 1'b1, 16'h0459, 16'h0367, 1'b1, 16'h0827, 1'b0, 1'b0);
        op4_check("bcd_err", 1'b1, 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
        op4_check("bin_noerr", 1'b0, 16'h000A, 16'h0000, 1'b0, 16'h000A, 1'b0, 1'b0);
        op4_check("bin_8000", 1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Second start two cycles into a run must be dropped.
        launch4(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        b4.start = 1'b1; b4.bcd = 1'b1; b4.a = 16'h1234; b4.b = 16'h1111; b4.cin = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        check("ign_busy", b4.busy, 1'b1);
        npulse = 0; s_cap = '0; c_cap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (b4.done) begin
                npulse++;
                s_cap = b4.s;
                c_cap = b4.cout;
            end
        end
        check("ign_pulses", npulse, 1);
        check("ign_s", s_cap, 16'h0000);
        check("ign_cout", c_cap, 1'b1);
        $display("op ignore_start: pulses=%0d s=%h cout=%0d", npulse, s_cap, c_cap);

        // Start during the done cycle is accepted.
        launch4(1'b0, 16'h1111, 16'h2222, 1'b0);
        wait4(lat);
        check("b2b_first_s", b4.s, 16'h3333);
        launch4(1'b1, 16'h0459, 16'h0367, 1'b1);
        wait4(lat2);
        check("b2b_gap", lat2 + 1, 5);
        check("b2b_s", b4.s, 16'h0827);
        check("b2b_cout", b4.cout, 1'b0);
        $display("op back_to_back: gap=%0d s=%h cout=%0d", lat2 + 1, b4.s, b4.cout);

        // Reset at digit 2 of a run, with cout still 1 from the previous result.
        op4_check("bin_pre_rst", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        launch4(1'b1, 16'h11AA, 16'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_err", b4.err, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_s", b4.s, 16'h0000);
        check("arst_cout", b4.cout, 1'b0);
        check("arst_busy", b4.busy, 1'b0);
        check("arst_done", b4.done, 1'b0);
        check("arst_err", b4.err, 1'b0);
        $display("op async_reset: s=%h cout=%0d busy=%0d done=%0d err=%0d",
                 b4.s, b4.cout, b4.busy, b4.done, b4.err);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (b4.done) nd++;
        end
        check("arst_nodone", nd, 0);
        op4_check("post_rst", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Exhaustive single-digit sweep against an arithmetic reference.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < (m ? 10 : 16); x++) begin
                for (int y = 0; y < (m ? 10 : 16); y++) begin
                    for (int c = 0; c < 2; c++) begin
                        op1(m[0], x[3:0], y[3:0], c[0], lat);
                        v = x + y + c;
                        if (m == 1) e = (v >= 10) ? (16 + v - 10) : v;
                        else        e = v;
                        check(m ? "sweep_bcd" : "sweep_bin", {b1.cout, b1.s}, e);
                        check("sweep_err", b1.err, 1'b0);
                        check("sweep_lat", lat, 1);
                        $display("op sweep bcd=%0d a=%0d b=%0d cin=%0d -> cout=%0d s=%h",
                                 m, x, y, c, b1.cout, b1.s);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
